// File: rtl/conv_frame_bridge.sv
// conv_frame_bridge
// Buffers one complete frame from an upstream conv block (y stream), then
// replays it, zero-padded to OUT_LEN words, into the next conv block
// (x stream). Filling and draining never overlap: while a frame is being
// replayed the upstream is held off.
//
// The RAM read register doubles as the x_data output register. Padding
// positions and idle cycles load zero into it instead of RAM contents.
// As a result x_data is always registered and is 0 whenever x_valid is 0.

module conv_frame_bridge #(
    parameter int WIDTH   = 16,
    parameter int IN_LEN  = 11,
    parameter int OUT_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] y_data,
    input  logic             y_valid,
    output logic             y_ready,
    output logic [WIDTH-1:0] x_data,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [7:0]       frame_count
);

    // Write index only ever addresses stored words. The read index must also
    // count the padding positions beyond IN_LEN.
    localparam int WA = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int RA = $clog2(OUT_LEN + 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [WA-1:0]    wr_idx_q;
    logic [RA-1:0]    rd_idx_q;
    logic             y_ready_q;
    logic             x_valid_q;
    logic [WIDTH-1:0] x_data_q;
    logic [7:0]       frame_count_q;

    logic [WIDTH-1:0] mem_q [IN_LEN];

    logic             y_hs_s;
    logic             x_hs_s;
    logic [RA-1:0]    rd_next_s;
    logic [RA-1:0]    rd_addr_s;
    logic             rd_in_range_s;
    logic [WA-1:0]    mem_addr_s;

    // Handshakes and the RAM read address presented this cycle.
    always_comb begin
        y_hs_s    = y_valid & y_ready_q;
        x_hs_s    = x_valid_q & x_ready;
        rd_next_s = rd_idx_q + {{(RA-1){1'b0}}, 1'b1};
        case (state_q)
            ST_LOAD: begin
                rd_addr_s = {RA{1'b0}};
            end
            ST_DRAIN: begin
                // Advance only on a handshake so a stalled word is re-read unchanged.
                if (x_hs_s) begin
                    rd_addr_s = rd_next_s;
                end else begin
                    rd_addr_s = rd_idx_q;
                end
            end
            default: begin
                rd_addr_s = {RA{1'b0}};
            end
        endcase
        rd_in_range_s = (rd_addr_s < RA'(IN_LEN));
        // Clamp padding addresses so the RAM is never indexed past its depth.
        if (rd_in_range_s) begin
            mem_addr_s = WA'(rd_addr_s);
        end else begin
            mem_addr_s = {WA{1'b0}};
        end
    end

    // Frame store write port. Writes happen only on accepted y words, and
    // y_ready is high only in FILL.
    always_ff @(posedge clk) begin
        if (y_hs_s) begin
            mem_q[wr_idx_q] <= y_data;
        end
    end

    // Fill/load/drain sequencer with registered stream outputs and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FILL;
            wr_idx_q      <= {WA{1'b0}};
            rd_idx_q      <= {RA{1'b0}};
            y_ready_q     <= 1'b0;
            x_valid_q     <= 1'b0;
            x_data_q      <= {WIDTH{1'b0}};
            frame_count_q <= 8'd0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    x_valid_q <= 1'b0;
                    x_data_q  <= {WIDTH{1'b0}};
                    // Raised here too, so y_ready comes up one cycle after reset release.
                    y_ready_q <= 1'b1;
                    if (y_hs_s) begin
                        if (wr_idx_q == WA'(IN_LEN - 1)) begin
                            state_q   <= ST_LOAD;
                            wr_idx_q  <= {WA{1'b0}};
                            y_ready_q <= 1'b0;
                        end else begin
                            wr_idx_q  <= wr_idx_q + {{(WA-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_LOAD: begin
                    // Address 0 is presented. Word 0 lands in the output register.
                    state_q   <= ST_DRAIN;
                    rd_idx_q  <= {RA{1'b0}};
                    y_ready_q <= 1'b0;
                    x_valid_q <= 1'b1;
                    x_data_q  <= rd_in_range_s ? mem_q[mem_addr_s] : {WIDTH{1'b0}};
                end
                ST_DRAIN: begin
                    y_ready_q <= 1'b0;
                    if (x_hs_s) begin
                        if (rd_idx_q == RA'(OUT_LEN - 1)) begin
                            state_q       <= ST_FILL;
                            rd_idx_q      <= {RA{1'b0}};
                            x_valid_q     <= 1'b0;
                            x_data_q      <= {WIDTH{1'b0}};
                            y_ready_q     <= 1'b1;
                            frame_count_q <= frame_count_q + 8'd1;
                        end else begin
                            rd_idx_q  <= rd_next_s;
                            x_valid_q <= 1'b1;
                            x_data_q  <= rd_in_range_s ? mem_q[mem_addr_s] : {WIDTH{1'b0}};
                        end
                    end else begin
                        // Stalled: hold the presented word until it is taken.
                        rd_idx_q  <= rd_idx_q;
                        x_valid_q <= 1'b1;
                        x_data_q  <= x_data_q;
                    end
                end
                default: begin
                    state_q   <= ST_FILL;
                    wr_idx_q  <= {WA{1'b0}};
                    rd_idx_q  <= {RA{1'b0}};
                    y_ready_q <= 1'b0;
                    x_valid_q <= 1'b0;
                    x_data_q  <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign y_ready     = y_ready_q;
    assign x_valid     = x_valid_q;
    assign x_data      = x_data_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_conv_frame_bridge.sv
// Scoreboard bench for conv_frame_bridge: stimulus pushes expected x words,
// monitors pop and compare on every x handshake.

module tb_conv_frame_bridge;

    localparam int W   = 16;
    localparam int IN  = 11;
    localparam int OUT = 16;
    localparam int L2  = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] y_data, x_data;
    logic         y_valid, y_ready, x_valid, x_ready;
    logic [7:0]   frame_count;

    logic [W-1:0] y2_data, x2_data;
    logic         y2_valid, y2_ready, x2_valid, x2_ready;
    logic [7:0]   frame_count2;

    always #5 clk = ~clk;

    conv_frame_bridge #(.WIDTH(W), .IN_LEN(IN), .OUT_LEN(OUT)) dut (
        .clk(clk), .reset(reset),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .frame_count(frame_count)
    );

    conv_frame_bridge #(.WIDTH(W), .IN_LEN(L2), .OUT_LEN(L2)) dut2 (
        .clk(clk), .reset(reset),
        .y_data(y2_data), .y_valid(y2_valid), .y_ready(y2_ready),
        .x_data(x2_data), .x_valid(x2_valid), .x_ready(x2_ready),
        .frame_count(frame_count2)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] sb2_q[$];
    int           pop_cnt  = 0;
    int           pop2_cnt = 0;
    int           xr_pct   = 100;
    int           exp_fc   = 0;
    logic [W-1:0] frame_buf[IN];
    logic         stalled  = 1'b0;
    logic [W-1:0] held     = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endfunction

    // Main-DUT monitor: scoreboard compare, stall stability, idle-zero, no-overlap.
    always @(negedge clk) begin
        if (reset) begin
            stalled <= 1'b0;
        end else begin
            if (!x_valid) chk("x_idle_zero", 32'(x_data), 32'd0);
            if (x_valid)  chk("y_ready_in_drain", 32'(y_ready), 32'd0);
            if (stalled) begin
                chk("stall_valid", 32'(x_valid), 32'd1);
                chk("stall_data", 32'(x_data), 32'(held));
            end
            if (x_valid && x_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL x_unexpected: actual=%0h required=none at %0t", x_data, $time);
                end else begin
                    chk("x_data", 32'(x_data), 32'(sb_q.pop_front()));
                    pop_cnt <= pop_cnt + 1;
                end
            end
            stalled <= x_valid && !x_ready;
            held    <= x_data;
        end
    end

    // Equal-length DUT monitor.
    always @(negedge clk) begin
        if (!reset && x2_valid && x2_ready) begin
            if (sb2_q.size() == 0) begin
                n_checks++;
                $display("FAIL x2_unexpected: actual=%0h required=none at %0t", x2_data, $time);
            end else begin
                chk("x2_data", 32'(x2_data), 32'(sb2_q.pop_front()));
                pop2_cnt <= pop2_cnt + 1;
            end
        end
    end

    // Downstream ready driver with a programmable acceptance percentage.
    initial begin
        x_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            x_ready = (int'($urandom_range(0, 99)) < xr_pct);
        end
    end

    // Watchdog against any hang.
    initial begin
        #900000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic send_words(input int n, input int vpct);
        bit hs;
        int guard;
        for (int i = 0; i < n; i++) begin
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 2000) begin
                if (int'($urandom_range(0, 99)) < vpct) begin
                    y_valid = 1'b1; y_data = frame_buf[i];
                end else begin
                    y_valid = 1'b0; y_data = 16'hDEAD;
                end
                @(negedge clk);
                hs = y_valid && y_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) begin
                n_checks++;
                $display("FAIL y_timeout: actual=word %0d not taken required=taken", i);
            end
        end
        y_valid = 1'b0;
        y_data  = '0;
    endtask

    task automatic push_expected();
        for (int i = 0; i < OUT; i++) sb_q.push_back((i < IN) ? frame_buf[i] : 16'h0000);
    endtask

    task automatic wait_drain(input bit junk);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0) begin done = 1'b1; break; end
            if (junk) begin y_valid = 1'b1; y_data = 16'h7E5A ^ 16'(i); end
            @(posedge clk); #1;
        end
        y_valid = 1'b0;
        y_data  = '0;
        if (!done) begin
            n_checks++;
            $display("FAIL drain_timeout: actual=%0d words left required=0", sb_q.size());
        end
        exp_fc = (exp_fc + 1) % 256;
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
        chk("y_ready_after_frame", 32'(y_ready), 32'd1);
    endtask

    task automatic do_reset();
        y_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_y_ready", 32'(y_ready), 32'd0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_x_data", 32'(x_data), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        exp_fc = 0;
        @(posedge clk); #1;
        chk("post_rst_y_ready", 32'(y_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_x_valid", 32'(x_valid), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int base;
        reset = 1'b1; y_valid = 1'b0; y_data = '0;
        y2_valid = 1'b0; y2_data = '0; x2_ready = 1'b1;
        do_reset();

        // Basic: 1..11, latency and exact valid window.
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(i + 1);
        send_words(IN, 100);
        push_expected();
        chk("load_x_valid", 32'(x_valid), 32'd0);
        chk("load_y_ready", 32'(y_ready), 32'd0);
        for (int k = 0; k < OUT; k++) begin
            @(posedge clk); #1;
            chk("drain_window_valid", 32'(x_valid), 32'd1);
        end
        @(posedge clk); #1;
        chk("window_end_valid", 32'(x_valid), 32'd0);
        chk("window_end_y_ready", 32'(y_ready), 32'd1);
        chk("basic_queue_empty", 32'(sb_q.size()), 32'd0);
        exp_fc = 1;
        chk("basic_frame_count", 32'(frame_count), 32'd1);

        // Sign and extremes.
        frame_buf[0] = 16'h8000; frame_buf[1] = 16'h7FFF; frame_buf[2] = 16'hFFFF;
        frame_buf[3] = 16'h0000; frame_buf[4] = 16'h0001; frame_buf[5] = 16'h8001;
        frame_buf[6] = 16'h7FFE; frame_buf[7] = 16'hFFFE; frame_buf[8] = 16'h0002;
        frame_buf[9] = 16'h5555; frame_buf[10] = 16'hAAAA;
        send_words(IN, 100);
        push_expected();
        wait_drain(1'b0);

        // Back-pressure at 30% ready.
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(16'h1100 + i * 3);
        xr_pct = 30;
        send_words(IN, 100);
        push_expected();
        wait_drain(1'b0);

        // Upstream gaps plus junk y_valid during drain.
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(16'hC000 - i * 5);
        xr_pct = 60;
        send_words(IN, 40);
        push_expected();
        wait_drain(1'b1);
        xr_pct = 100;
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(16'h0A00 + i);
        send_words(IN, 100);
        push_expected();
        wait_drain(1'b0);

        // Reset after the 5th y word.
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(16'h3300 + i);
        send_words(5, 100);
        do_reset();

        // Reset after the 7th x word.
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(16'h4400 + i);
        send_words(IN, 100);
        push_expected();
        base = pop_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (pop_cnt >= base + 7) break;
        end
        chk("seven_popped", 32'(pop_cnt - base), 32'd7);
        #1;
        do_reset();

        // Next full frame after reset.
        for (int i = 0; i < IN; i++) frame_buf[i] = 16'(16'h5500 + i * 9);
        send_words(IN, 100);
        push_expected();
        wait_drain(1'b0);

        // 257 back-to-back frames with wrap of frame_count.
        do_reset();
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < IN; i++) frame_buf[i] = 16'(f * 1000 + i * 7 + 3);
            send_words(IN, 100);
            push_expected();
            wait_drain(1'b0);
        end
        chk("wrap_frame_count", 32'(frame_count), 32'd1);

        // Equal lengths: exactly 16 nonzero words per frame, no padding.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < L2; i++) begin
                y2_valid = 1'b1;
                y2_data  = (f == 0) ? 16'(16'h0100 + i) : 16'(16'hFF00 - i);
                sb2_q.push_back(y2_data);
                for (int g = 0; g < 100; g++) begin
                    @(negedge clk);
                    if (y2_ready) begin
                        @(posedge clk); #1;
                        break;
                    end
                    @(posedge clk); #1;
                end
            end
            y2_valid = 1'b0;
            for (int g = 0; g < 100; g++) begin
                @(posedge clk); #1;
                if (sb2_q.size() == 0 && y2_ready) break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("eq_word_count", 32'(pop2_cnt), 32'd32);
        chk("eq_frame_count", 32'(frame_count2), 32'd2);
        chk("eq_queue_empty", 32'(sb2_q.size()), 32'd0);
        chk("main_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_frame_bridge.md
# conv_frame_bridge

Frame buffer that sits between two convolution layers. It receives one complete output frame of an upstream conv block over its y_data/y_valid/y_ready stream and stores it. It then transmits the frame, zero-padded to the downstream input length, over an x_data/x_valid/x_ready stream into the next conv block. This makes it the producer end of the x handshake and the consumer end of the y handshake that every conv block in the design uses.

## Interface
- WIDTH, 16, sample width in bits (signed two's complement, passed through unmodified)
- IN_LEN, 11, words per received frame (upstream X-F+1)
- OUT_LEN, 16, words per transmitted frame; legal range IN_LEN <= OUT_LEN
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- y_data  input  WIDTH  upstream sample
- y_valid  input  1  upstream sample valid
- y_ready  output  1  bridge accepts y_data
- x_data  output  WIDTH  downstream sample
- x_valid  output  1  x_data valid
- x_ready  input  1  downstream accepts x_data
- frame_count  output  8  frames fully transmitted since reset, wraps 255->0

## Operation
- Storage: IN_LEN x WIDTH RAM, synchronous read (data one cycle after address), synchronous write.
- States: FILL, LOAD, DRAIN. Reset enters FILL with wr_idx=0, rd_idx=0, frame_count=0.
- FILL:
  - y_ready=1, x_valid=0.
  - On y_valid&y_ready, write y_data to mem[wr_idx] and increment wr_idx.
  - The handshake with wr_idx==IN_LEN-1 moves to LOAD and clears wr_idx.
- LOAD:
  - y_ready=0, x_valid=0.
  - Read address 0 is presented. rd_idx=0. Unconditionally goes to DRAIN next cycle.
- DRAIN:
  - y_ready=0, x_valid=1.
  - x_data = RAM read data when rd_idx<IN_LEN, otherwise 0 (padding).
  - Read address is rd_idx+1 when x_valid&x_ready is true, else rd_idx, so x_data stays stable while stalled.
  - On handshake, rd_idx increments.
  - The handshake with rd_idx==OUT_LEN-1 returns to FILL, clears rd_idx and increments frame_count.
- No overlap: the upstream is back-pressured for the whole of LOAD and DRAIN, and no y word is accepted while a frame drains.
- Data is never altered: no saturation, no ReLU, no sign change.
- x_data must be 0 whenever x_valid=0.

## Timing
- Reset values: y_ready=0 while reset is asserted, 1 in the first cycle after release; x_valid=0; x_data=0; frame_count=0.
- Reset asserted mid-frame, in any state: return to FILL immediately, discard partial contents, clear all indices and frame_count. No x_valid pulse may follow the release of reset.
- Latency: the last y handshake at edge t gives LOAD in cycle t+1 and x_valid=1 with word 0 in cycle t+2.
- Throughput in DRAIN: one word per cycle when x_ready is held at 1.
- Back-pressure: x_valid must not drop and x_data must not change until a handshake occurs. x_ready may toggle arbitrarily.
- Upstream: y_valid may toggle; only cycles with y_valid=1 in FILL store data.
- After the final x handshake at edge t, y_ready=1 in cycle t+1. Minimum frame period is IN_LEN+OUT_LEN+1 cycles.
- y_valid asserted in LOAD/DRAIN: ignored, and no write occurs.
- When IN_LEN==OUT_LEN, no padding words are emitted.

## Test plan
- Basic: IN_LEN=11, OUT_LEN=16, send y=1..11 with y_valid held high, x_ready=1 -> x stream is 1..11 then five 0s, and x_valid is high for exactly 16 consecutive cycles starting 2 cycles after the 11th y handshake; frame_count goes to 1.
- Sign/extremes: send -32768, 32767, -1, 0, ... -> identical values on x_data; padding stays 0.
- Back-pressure: x_ready random at 30% -> same 16-word sequence, x_data stable across every stall, no duplicated or dropped words; y_ready=0 throughout DRAIN.
- Upstream gaps and illegal valid: y_valid random in FILL, and y_valid=1 during DRAIN with junk data -> only FILL-phase words appear, and the junk is never written.
- Reset mid-operation: assert reset after the 5th y word, and again after the 7th x word -> x_valid=0 and frame_count=0 after each reset. The next full frame transmits correctly.
- Back-to-back and wrap: 257 frames with distinct data -> every frame is correct and frame_count reads 1 after frame 257 (wrapped). With IN_LEN=OUT_LEN=16, no zero padding appears.
